fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / multi-cycle / WAW stall detection,
// a multi-cycle result scoreboard and a saturating stall-cycle counter.
module fwd_hazard_unit #(
   parameter int NSRC = 2,
   parameter int AW   = 5,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC*AW-1:0]   ifid_rs,
   input  logic [NSRC-1:0]      ifid_rs_use,
   input  logic [AW-1:0]        ifid_rd,
   input  logic                 ifid_regwr,
   input  logic [NSRC*AW-1:0]   idex_rs,
   input  logic [AW-1:0]        idex_rd,
   input  logic                 idex_regwr,
   input  logic                 idex_memrd,
   input  logic                 idex_mc,
   input  logic [AW-1:0]        exmem_rd,
   input  logic                 exmem_regwr,
   input  logic [AW-1:0]        memwb_rd,
   input  logic                 memwb_regwr,
   input  logic                 mc_done,
   input  logic [AW-1:0]        mc_done_rd,
   input  logic                 cnt_clr,
   output logic [NSRC*2-1:0]    fwd_sel,
   output logic                 stall,
   output logic                 flush_idex,
   output logic [2**AW-1:0]     sb_busy,
   output logic [CNTW-1:0]      stall_cnt
);

   logic              idex_wr_nz;
   logic              load_use;
   logic              mc_raw;
   logic              waw;
   logic [2**AW-1:0]  sb_nxt;

   assign idex_wr_nz = idex_regwr && (idex_rd != '0);

   // EX/MEM is the younger producer, so it wins over MEM/WB
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (exmem_regwr && exmem_rd != '0 &&
             exmem_rd == idex_rs[i*AW +: AW])
            fwd_sel[i*2 +: 2] = 2'b10;
         else if (memwb_regwr && memwb_rd != '0 &&
                  memwb_rd == idex_rs[i*AW +: AW])
            fwd_sel[i*2 +: 2] = 2'b01;
      end
   end

   always_comb begin
      load_use = 1'b0;
      mc_raw   = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (ifid_rs_use[i]) begin
            if (idex_wr_nz && ifid_rs[i*AW +: AW] == idex_rd) begin
               load_use = load_use | idex_memrd;
               mc_raw   = mc_raw | idex_mc;
            end
            if (sb_busy[ifid_rs[i*AW +: AW]])
               mc_raw = 1'b1;
         end
      end
   end

   assign waw        = ifid_regwr && (ifid_rd != '0) && sb_busy[ifid_rd];
   assign stall      = load_use | mc_raw | waw;
   assign flush_idex = stall;

   // set is applied after clear so a same-cycle issue keeps the bit busy
   always_comb begin
      sb_nxt = sb_busy;
      if (mc_done)
         sb_nxt[mc_done_rd] = 1'b0;
      if (idex_mc && idex_wr_nz)
         sb_nxt[idex_rd] = 1'b1;
      sb_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sb_busy <= '0;
      else
         sb_busy <= sb_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (cnt_clr)
         stall_cnt <= '0;
      else if (stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNTW'(1);
   end

endmodule
